// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay mixer: fade state encoding,
// full-scale alpha weight and packed RGB width.
package overlay_pkg;

   typedef enum logic [1:0] {
      HIDDEN   = 2'd0,
      FADE_IN  = 2'd1,
      SHOWN    = 2'd2,
      FADE_OUT = 2'd3
   } ovl_state_e;

   localparam logic [2:0] ALPHA_MAX = 3'd4;
   localparam int         RGB_W     = 6;

endpackage

// File: rtl/overlay_blend_channel.sv
// One 2-bit colour channel blend: y = floor((o*a + b*(4-a)) / 4), a in 0..4.
module overlay_blend_channel
   import overlay_pkg::*;
(
   input  logic [1:0] o,
   input  logic [1:0] b,
   input  logic [2:0] a,
   output logic [1:0] y
);

   logic [3:0] m;

   // 3*4 = 12 is the largest weighted sum, so 4 bits never overflow
   always_comb m = 4'(o) * 4'(a) + 4'(b) * (4'(ALPHA_MAX) - 4'(a));

   assign y = 2'(m >> 2);

endmodule

// File: rtl/overlay_mixer.sv
// Final VGA pixel stage: alpha-blends the overlay over the background with a
// frame-timed fade, and registers RGB together with both syncs.
//
//   state    | meaning
//   HIDDEN   | overlay invisible, alpha = 0
//   FADE_IN  | alpha steps up by one every STEP_FRAMES frame ticks
//   SHOWN    | overlay fully opaque, alpha = 4
//   FADE_OUT | alpha steps down by one every STEP_FRAMES frame ticks
module overlay_mixer
   import overlay_pkg::*;
#(
   parameter int STEP_FRAMES      = 8,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RGB_W-1:0] bg_rgb,
   input  logic [RGB_W-1:0] overlay_rgb,
   input  logic             overlay_active,
   input  logic             frame_active,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             overlay_en,
   output logic [RGB_W-1:0] rgb_out,
   output logic             hsync_out,
   output logic             vsync_out,
   output logic [2:0]       alpha,
   output logic             fading
);

   localparam logic       VS_IDLE   = VSYNC_ACTIVE_LOW;
   localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

   ovl_state_e       state_q, state_d;
   logic [2:0]       alpha_q, alpha_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             vs_prev_q;
   logic             tick;
   logic             step;
   logic [RGB_W-1:0] mix;

   // vsync_out is the first stage of the edge detector, vs_prev_q the second
   assign tick = (vsync_out != VS_IDLE) && (vs_prev_q == VS_IDLE);
   assign step = tick && (cnt_q == STEP_LAST);

   always_comb begin
      state_d = state_q;
      alpha_d = alpha_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         HIDDEN: begin
            if (overlay_en) state_d = FADE_IN;
         end
         FADE_IN: begin
            if (!overlay_en)              state_d = FADE_OUT;
            else if (alpha_q >= ALPHA_MAX) state_d = SHOWN;
            else if (step) begin
               alpha_d = alpha_q + 3'd1;
               cnt_d   = '0;
            end else if (tick) cnt_d = cnt_q + 8'd1;
         end
         SHOWN: begin
            if (!overlay_en) state_d = FADE_OUT;
         end
         FADE_OUT: begin
            if (overlay_en)         state_d = FADE_IN;
            else if (alpha_q == '0) state_d = HIDDEN;
            else if (step) begin
               alpha_d = alpha_q - 3'd1;
               cnt_d   = '0;
            end else if (tick) cnt_d = cnt_q + 8'd1;
         end
         default: state_d = HIDDEN;
      endcase
      // a state change overrides any coincident tick, so no step is taken
      if (state_d != state_q) cnt_d = '0;
   end

   overlay_blend_channel u_blend_r (
      .o (overlay_rgb[5:4]), .b (bg_rgb[5:4]), .a (alpha_q), .y (mix[5:4])
   );
   overlay_blend_channel u_blend_g (
      .o (overlay_rgb[3:2]), .b (bg_rgb[3:2]), .a (alpha_q), .y (mix[3:2])
   );
   overlay_blend_channel u_blend_b (
      .o (overlay_rgb[1:0]), .b (bg_rgb[1:0]), .a (alpha_q), .y (mix[1:0])
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= HIDDEN;
         alpha_q   <= '0;
         cnt_q     <= '0;
         rgb_out   <= '0;
         hsync_out <= 1'b1;
         vsync_out <= VS_IDLE;
         vs_prev_q <= VS_IDLE;
      end else begin
         state_q   <= state_d;
         alpha_q   <= alpha_d;
         cnt_q     <= cnt_d;
         hsync_out <= hsync_in;
         vsync_out <= vsync_in;
         vs_prev_q <= vsync_out;
         if (!frame_active)        rgb_out <= '0;
         else if (!overlay_active) rgb_out <= bg_rgb;
         else                      rgb_out <= mix;
      end
   end

   assign alpha  = alpha_q;
   assign fading = (state_q == FADE_IN) || (state_q == FADE_OUT);

endmodule

// File: tb/tb_overlay_mixer.sv
// Scoreboard bench for overlay_mixer: stimulus queues expected outputs tagged
// with the cycle they are due, a negedge monitor pops and compares them.
module tb_overlay_mixer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] bg_rgb, overlay_rgb;
   logic       overlay_active, frame_active, hsync_in, vsync_in, overlay_en;
   logic [5:0] rgb_out;
   logic       hsync_out, vsync_out, fading;
   logic [2:0] alpha;

   int cyc     = 0;
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         due;
      string      name;
      logic [4:0] mask;   // [0] rgb [1] hsync [2] vsync [3] alpha [4] fading
      logic [5:0] rgb;
      logic       hs;
      logic       vs;
      logic [2:0] al;
      logic       fd;
   } exp_t;

   exp_t sbq[$];

   overlay_mixer #(.STEP_FRAMES(2), .VSYNC_ACTIVE_LOW(1'b1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bg_rgb         (bg_rgb),
      .overlay_rgb    (overlay_rgb),
      .overlay_active (overlay_active),
      .frame_active   (frame_active),
      .hsync_in       (hsync_in),
      .vsync_in       (vsync_in),
      .overlay_en     (overlay_en),
      .rgb_out        (rgb_out),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .alpha          (alpha),
      .fading         (fading)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
         e = sbq.pop_front();
         if (e.mask[0]) begin
            n_tests++;
            if (rgb_out !== e.rgb) begin
               n_fail++;
               $display("FAIL %s rgb_out got %b want %b", e.name, rgb_out, e.rgb);
            end
         end
         if (e.mask[1]) begin
            n_tests++;
            if (hsync_out !== e.hs) begin
               n_fail++;
               $display("FAIL %s hsync_out got %b want %b", e.name, hsync_out, e.hs);
            end
         end
         if (e.mask[2]) begin
            n_tests++;
            if (vsync_out !== e.vs) begin
               n_fail++;
               $display("FAIL %s vsync_out got %b want %b", e.name, vsync_out, e.vs);
            end
         end
         if (e.mask[3]) begin
            n_tests++;
            if (alpha !== e.al) begin
               n_fail++;
               $display("FAIL %s alpha got %0d want %0d", e.name, alpha, e.al);
            end
         end
         if (e.mask[4]) begin
            n_tests++;
            if (fading !== e.fd) begin
               n_fail++;
               $display("FAIL %s fading got %b want %b", e.name, fading, e.fd);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // expectation for the outputs after the next active edge
   task automatic expect_out(input string nm, input logic [4:0] mask, input logic [5:0] rgb,
                             input logic hs, input logic vs, input logic [2:0] al,
                             input logic fd);
      exp_t e;
      e.due  = cyc + 1;
      e.name = nm;
      e.mask = mask;
      e.rgb  = rgb;
      e.hs   = hs;
      e.vs   = vs;
      e.al   = al;
      e.fd   = fd;
      sbq.push_back(e);
   endtask

   // one vblank pulse (active-low vsync); drop clears overlay_en on the tick cycle
   task automatic frame(input bit drop);
      vsync_in = 1'b0;
      step();
      if (drop) overlay_en = 1'b0;
      step();
      vsync_in = 1'b1;
      repeat (3) step();
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) frame(1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bg_rgb         = '0;
      overlay_rgb    = '0;
      overlay_active = 1'b0;
      frame_active   = 1'b0;
      hsync_in       = 1'b1;
      vsync_in       = 1'b1;
      overlay_en     = 1'b0;
      repeat (2) step();

      // reset with inputs toggling
      for (int i = 0; i < 4; i++) begin
         bg_rgb         = 6'($urandom);
         overlay_rgb    = 6'($urandom);
         overlay_active = 1'($urandom);
         frame_active   = 1'b1;
         hsync_in       = i[0];
         vsync_in       = ~i[0];
         overlay_en     = 1'b1;
         expect_out("reset", 5'b11111, 6'b0, 1'b1, 1'b1, 3'd0, 1'b0);
         step();
      end

      overlay_en = 1'b0;
      hsync_in   = 1'b1;
      vsync_in   = 1'b1;
      step();
      rst_n = 1'b1;
      step();

      // passthrough while hidden, syncs delayed one cycle
      bg_rgb = 6'b10_01_11; overlay_rgb = 6'b11_11_11;
      overlay_active = 1'b1; frame_active = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
      expect_out("pass_a", 5'b11111, 6'b10_01_11, 1'b0, 1'b1, 3'd0, 1'b0);
      step();
      bg_rgb = 6'b01_01_10; overlay_active = 1'b0; hsync_in = 1'b1; vsync_in = 1'b0;
      expect_out("pass_b", 5'b11111, 6'b01_01_10, 1'b1, 1'b0, 3'd0, 1'b0);
      step();
      vsync_in = 1'b1;
      expect_out("pass_c", 5'b11111, 6'b01_01_10, 1'b1, 1'b1, 3'd0, 1'b0);
      step();
      step();

      // fade in, two frames per step
      bg_rgb = 6'b00_00_00; overlay_rgb = 6'b11_11_11; overlay_active = 1'b1;
      overlay_en = 1'b1;
      expect_out("fadein_start", 5'b11111, 6'b00_00_00, 1'b1, 1'b1, 3'd0, 1'b1);
      step();
      frames(2);
      expect_out("fadein_a1", 5'b11111, 6'b00_00_00, 1'b1, 1'b1, 3'd1, 1'b1);
      step();
      frames(2);
      expect_out("fadein_a2", 5'b11111, 6'b01_01_01, 1'b1, 1'b1, 3'd2, 1'b1);
      step();
      frames(2);
      expect_out("fadein_a3", 5'b11111, 6'b10_10_10, 1'b1, 1'b1, 3'd3, 1'b1);
      step();
      frames(2);
      expect_out("shown_a4", 5'b11111, 6'b11_11_11, 1'b1, 1'b1, 3'd4, 1'b0);
      step();

      // blanking beats an opaque overlay
      frame_active = 1'b0;
      expect_out("blank", 5'b11111, 6'b00_00_00, 1'b1, 1'b1, 3'd4, 1'b0);
      step();
      frame_active = 1'b1;
      step();

      // fade out 4 -> 2, then reverse into fade in at alpha 2
      overlay_en = 1'b0;
      expect_out("fadeout_start", 5'b11111, 6'b11_11_11, 1'b1, 1'b1, 3'd4, 1'b1);
      step();
      frames(2);
      expect_out("fadeout_a3", 5'b11111, 6'b10_10_10, 1'b1, 1'b1, 3'd3, 1'b1);
      step();
      frames(2);
      expect_out("fadeout_a2", 5'b11111, 6'b01_01_01, 1'b1, 1'b1, 3'd2, 1'b1);
      step();
      overlay_en = 1'b1;
      expect_out("rev_in_a2", 5'b11000, 6'b0, 1'b1, 1'b1, 3'd2, 1'b1);
      step();
      frame(1'b0);
      expect_out("rev_in_half", 5'b11000, 6'b0, 1'b1, 1'b1, 3'd2, 1'b1);
      step();
      // drop coincides with the tick that would have completed the step
      frame(1'b1);
      expect_out("rev_drop_nostep", 5'b11000, 6'b0, 1'b1, 1'b1, 3'd2, 1'b1);
      step();
      overlay_rgb = 6'b01_11_00; bg_rgb = 6'b10_00_11;
      frames(2);
      expect_out("rev_out_a1", 5'b11111, 6'b01_00_10, 1'b1, 1'b1, 3'd1, 1'b1);
      step();
      frames(2);
      expect_out("rev_hidden", 5'b11111, 6'b10_00_11, 1'b1, 1'b1, 3'd0, 1'b0);
      step();

      // fade in to alpha 3, then long stretch with no frame tick
      overlay_en = 1'b1;
      step();
      frames(6);
      expect_out("mid_a3", 5'b11111, 6'b01_10_00, 1'b1, 1'b1, 3'd3, 1'b1);
      step();
      for (int i = 0; i < 60; i++) begin
         hsync_in = (i % 8) < 2 ? 1'b0 : 1'b1;
         if (i % 10 == 0)
            expect_out("mid_stable", 5'b11011, 6'b01_10_00, hsync_in, 1'b1, 3'd3, 1'b1);
         step();
      end
      hsync_in = 1'b1;
      rst_n = 1'b0;
      expect_out("mid_reset", 5'b11111, 6'b0, 1'b1, 1'b1, 3'd0, 1'b0);
      step();
      rst_n = 1'b1;
      repeat (3) step();

      if (sbq.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain pending got %0d want 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
